parity_stream_checker: RTL and testbench
========================================

// Module: parity_stream_checker
// PURPOSE
//  Streaming, parametrised parity checker for framed data words; successor to the 4-bit even parity checker.
//  Each word arrives with its own parity bit. Parity mode (even/odd) is selectable per frame.
//  Produces a registered per-word error, a frame-level error on the last word, and a saturating error counter.
//  Sits between a serial/link receiver and downstream consumers; valid/ready on both sides.
// PARAMETERS
//  DATA_W  8  data word width in bits (>=1)
//  CNT_W   8  width of saturating word-error counter (>=1)
// PORTS
//  clk            in   1        clock, all logic on rising edge
//  rst            in   1        synchronous reset, active-high
//  in_valid       in   1        input word valid
//  in_ready       out  1        input word can be accepted
//  in_data        in   DATA_W   data word
//  in_parity      in   1        parity bit sent with word
//  in_last        in   1        word is last of its frame
//  odd_mode       in   1        0=even, 1=odd parity; sampled on first word of a frame only
//  out_valid      out  1        result valid
//  out_ready      in   1        downstream accepts result
//  out_word_err   out  1        parity error on this word
//  out_last       out  1        this result is for last word of frame
//  out_frame_err  out  1        on out_last beat: any word in frame failed; 0 on non-last beats
//  err_count      out  CNT_W    total erroneous words since reset/clear, saturating
//  clr_count      in   1        synchronous clear of err_count
// BEHAVIOUR
//  - Reset: out_valid=0, out_word_err=0, out_last=0, out_frame_err=0, err_count=0, FSM=IDLE, sticky frame error=0.
//  - in_ready = !rst && (!out_valid || out_ready). Single output register, no skid buffer.
//  - Accept = in_valid && in_ready. Result registered: out_valid rises the cycle after accept (latency 1).
//  - Back-to-back full throughput when out_ready held high.
//  - out_valid && !out_ready: all out_* and in_ready=0 held stable until out_ready.
//  - out_valid drops after handshake if no new accept in same cycle.
//  - Word error: e = ^in_data ^ in_parity ^ m, with m = effective mode.
//    Even: ones(data)+parity must be even. Odd: must be odd.
//  - FSM IDLE (no frame open) / ACTIVE (frame open):
//    - IDLE + accept: m = odd_mode, latched into frame_mode. in_last=1 -> stay IDLE (one-word frame), else -> ACTIVE.
//    - ACTIVE + accept: m = frame_mode; odd_mode ignored. in_last=1 -> IDLE.
//    - No accept: state holds.
//  - Sticky frame error:
//    - OR of e over accepted words of the open frame.
//    - On accept of last word: out_frame_err = sticky | e; sticky cleared to 0.
//  - err_count:
//    - +1 per accepted word with e=1; saturates at 2^CNT_W-1 (no wrap).
//    - clr_count alone -> 0.
//    - clr_count with erroneous accept in the same cycle -> 1.
//  - Reset mid-frame: frame discarded, no output for it. Next accepted word starts a new frame and re-samples odd_mode.
//  - No timeout on open frames; a frame stays ACTIVE until in_last is accepted.
// TESTING (DATA_W=8 unless noted)
//  1. Even mode, 8'hA5 p=0 last=1 -> out_word_err=0, out_frame_err=0, out_last=1, err_count=0, out_valid 1 cycle after accept.
//  2. Even mode, 8'h01 p=0 -> word_err=1. Same word, odd mode next frame -> word_err=0.
//  3. Even 3-word frame: 8'h03/p0, 8'h07/p0, 8'hFF/p0 last.
//     -> word_err 0,1,0; frame_err 0,0,1; err_count=1.
//     Also toggle odd_mode mid-frame -> no effect.
//  4. Hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, outputs stable, no words lost.
//     Release -> remaining words checked in order at one per cycle.
//  5. CNT_W=2: 5 bad words -> err_count=3 (saturated). clr_count with a bad accept in the same cycle -> err_count=1.
//  6. Assert rst after 2 words (one bad) of an open frame, then send a clean one-word frame in odd mode.
//     -> out_frame_err=0, odd_mode re-sampled, err_count=0.

Source files
------------

// File: rtl/parity_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : parity_stream_checker
// Description : Streaming per-word parity checker with per-frame parity mode,
//               frame-level sticky error and saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_stream_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    input  logic              in_last,
    input  logic              odd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_word_err,
    output logic              out_last,
    output logic              out_frame_err,
    output logic [CNT_W-1:0]  err_count,
    input  logic              clr_count
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_frame_mode;
    logic             r_sticky;
    logic             r_out_valid;
    logic             r_out_word_err;
    logic             r_out_last;
    logic             r_out_frame_err;
    logic [CNT_W-1:0] r_err_count;

    logic             w_accept;
    logic             w_mode;
    logic             w_word_err;
    logic             w_cnt_inc;

    // Single output stage: accept only when it is empty or draining this cycle.
    assign in_ready   = !rst && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_word_err = (^in_data) ^ in_parity ^ w_mode;
    assign w_cnt_inc  = w_accept && w_word_err;

    always_comb begin
        w_state_next = r_state;
        w_mode       = r_frame_mode;
        case (r_state)
            S_IDLE: begin
                // The first word of a frame carries the mode for the whole frame.
                w_mode = odd_mode;
                if (w_accept && !in_last) begin
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_accept && in_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_frame_mode <= 1'b0;
            r_sticky     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                if (r_state == S_IDLE) begin
                    r_frame_mode <= odd_mode;
                end
                r_sticky <= in_last ? 1'b0 : (r_sticky | w_word_err);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_out_word_err  <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_frame_err <= 1'b0;
        end else if (w_accept) begin
            r_out_valid     <= 1'b1;
            r_out_word_err  <= w_word_err;
            r_out_last      <= in_last;
            r_out_frame_err <= in_last && (r_sticky || w_word_err);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A clear coinciding with an erroneous word leaves that word counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (clr_count) begin
            r_err_count <= w_cnt_inc ? C_CNT_ONE : '0;
        end else if (w_cnt_inc && (r_err_count != C_CNT_MAX)) begin
            r_err_count <= r_err_count + C_CNT_ONE;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_word_err  = r_out_word_err;
    assign out_last      = r_out_last;
    assign out_frame_err = r_out_frame_err;
    assign err_count     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_parity_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_stream_checker
// Description : Scoreboard bench; two checkers (8-bit and 2-bit counters)
//               share one input stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_stream_checker;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       in_parity = 1'b0;
    logic       in_last   = 1'b0;
    logic       odd_mode  = 1'b0;
    logic       out_ready = 1'b1;
    logic       clr_count = 1'b0;

    logic       in_ready_a, out_valid_a, we_a, last_a, fe_a;
    logic [7:0] cnt_a;
    logic       in_ready_b, out_valid_b, we_b, last_b, fe_b;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    parity_stream_checker #(.DATA_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_parity(in_parity), .in_last(in_last),
        .odd_mode(odd_mode), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_word_err(we_a), .out_last(last_a), .out_frame_err(fe_a),
        .err_count(cnt_a), .clr_count(clr_count)
    );

    parity_stream_checker #(.DATA_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_parity(in_parity), .in_last(in_last),
        .odd_mode(odd_mode), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_word_err(we_b), .out_last(last_b), .out_frame_err(fe_b),
        .err_count(cnt_b), .clr_count(clr_count)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic we;
        logic last;
        logic fe;
    } exp_t;

    exp_t sb[$];
    int   m_cnt8   = 0;
    int   m_cnt2   = 0;
    logic m_active = 1'b0;
    logic m_mode   = 1'b0;
    logic m_sticky = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: evaluated on the falling edge for the coming rising edge.
    always @(negedge clk) begin : monitor
        logic rdy, acc, m, e;
        exp_t x;
        rdy = !rst && (sb.size() == 0 || out_ready);
        check_eq("in_ready_a", in_ready_a, rdy);
        check_eq("in_ready_b", in_ready_b, rdy);
        check_eq("out_valid_a", out_valid_a, sb.size() != 0);
        check_eq("out_valid_b", out_valid_b, sb.size() != 0);
        check_eq("err_count_a", cnt_a, m_cnt8[7:0]);
        check_eq("err_count_b", cnt_b, m_cnt2[1:0]);
        if (sb.size() != 0) begin
            check_eq("word_err_a", we_a, sb[0].we);
            check_eq("last_a", last_a, sb[0].last);
            check_eq("frame_err_a", fe_a, sb[0].fe);
            check_eq("word_err_b", we_b, sb[0].we);
            check_eq("frame_err_b", fe_b, sb[0].fe);
            if (out_ready && !rst) void'(sb.pop_front());
        end
        if (rst) begin
            sb.delete();
            m_cnt8   = 0;
            m_cnt2   = 0;
            m_active = 1'b0;
            m_mode   = 1'b0;
            m_sticky = 1'b0;
        end else begin
            acc = in_valid && rdy;
            m   = m_active ? m_mode : odd_mode;
            e   = (^in_data) ^ in_parity ^ m;
            if (clr_count) begin
                m_cnt8 = (acc && e) ? 1 : 0;
                m_cnt2 = (acc && e) ? 1 : 0;
            end else if (acc && e) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (acc) begin
                x.we   = e;
                x.last = in_last;
                x.fe   = in_last ? (m_sticky | e) : 1'b0;
                sb.push_back(x);
                if (!m_active) m_mode = odd_mode;
                m_sticky = in_last ? 1'b0 : (m_sticky | e);
                m_active = !in_last;
            end
        end
    end

    // Called and returns at 1 time unit after a rising edge.
    task automatic send(input logic [7:0] d, input logic p, input logic l, input logic om);
        int n;
        n         = 0;
        in_data   = d;
        in_parity = p;
        in_last   = l;
        odd_mode  = om;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("send_timeout", in_ready_a, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        clr_count = 1'b1;
        idle();
        clr_count = 1'b0;
    endtask

    initial begin : stim
        int t0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid_a, 0);
        check_eq("rst_err_count", cnt_a, 0);
        rst = 1'b0;

        // One-word clean frame, latency of one cycle.
        send(8'hA5, 1'b0, 1'b1, 1'b0);
        check_eq("t1_latency", out_valid_a, 1);
        check_eq("t1_word_err", we_a, 0);
        idle();

        // Same word, even then odd mode.
        send(8'h01, 1'b0, 1'b1, 1'b0);
        check_eq("t2_even_err", we_a, 1);
        send(8'h01, 1'b0, 1'b1, 1'b1);
        check_eq("t2_odd_err", we_a, 0);
        idle();

        // Three-word frame, odd_mode toggled mid-frame.
        clear();
        send(8'h03, 1'b0, 1'b0, 1'b0);
        send(8'h07, 1'b0, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1, 1'b1);
        check_eq("t3_frame_err", fe_a, 1);
        idle();
        idle();
        check_eq("t3_err_count", cnt_a, 1);

        // Downstream stall with input pending.
        fork
            begin
                send(8'h11, 1'b1, 1'b0, 1'b0);
                send(8'h12, 1'b0, 1'b0, 1'b1);
                send(8'h13, 1'b1, 1'b1, 1'b1);
                send(8'h80, 1'b1, 1'b0, 1'b1);
                send(8'h81, 1'b1, 1'b1, 1'b0);
                idle();
            end
            begin
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle();
        t0 = cycle;
        for (int i = 0; i < 4; i++) send(8'(i * 37), i[0], i == 3, 1'b0);
        check_eq("throughput", cycle - t0, 4);
        idle();

        // Saturation of the narrow counter, then clear with a bad word.
        clear();
        for (int i = 0; i < 5; i++) send(8'h01, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        check_eq("t5_sat_b", cnt_b, 3);
        check_eq("t5_cnt_a", cnt_a, 5);
        clr_count = 1'b1;
        send(8'h01, 1'b0, 1'b1, 1'b0);
        clr_count = 1'b0;
        idle();
        check_eq("t5_clr_bad_b", cnt_b, 1);
        check_eq("t5_clr_bad_a", cnt_a, 1);

        // Reset in the middle of an open frame.
        send(8'h01, 1'b0, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        send(8'h01, 1'b0, 1'b1, 1'b1);
        check_eq("t6_word_err", we_a, 0);
        check_eq("t6_frame_err", fe_a, 0);
        check_eq("t6_err_count", cnt_a, 0);
        repeat (3) idle();
        check_eq("end_out_valid", out_valid_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
